// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter states and grant owner.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    FAULT  = 2'd3
  } arbstate_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/access_watchdog.sv
// Counts grant cycles that did not see ACCESS; flags the cycle whose increment reaches TIMEOUT.
module access_watchdog
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Asserted one cycle early so the arbiter enters FAULT on the same edge the count hits TIMEOUT.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache requests onto a single RAM port with alternating priority and fault detection.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        fault
);

  arbstate_t state;
  grant_t    last_grant;
  ramstate_t rs;
  logic      d_req;
  logic      in_grant;
  logic      expired;

  assign rs       = ramstate_t'(ramstate);
  assign d_req    = dREN | dWEN;
  assign in_grant = (state == DGRANT) || (state == IGRANT);
  assign fault    = (state == FAULT);

  access_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (!in_grant),
    .enable (in_grant && (rs != ACCESS)),
    .expired(expired)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !(iREN && (last_grant == GRANT_D))) begin
            state      <= DGRANT;
            last_grant <= GRANT_D;
          end else if (iREN) begin
            state      <= IGRANT;
            last_grant <= GRANT_I;
          end
        end
        DGRANT: begin
          if (rs == ERROR)       state <= FAULT;
          else if (!d_req)       state <= IDLE;
          else if (rs == ACCESS) state <= IDLE;
          else if (expired)      state <= FAULT;
        end
        IGRANT: begin
          if (rs == ERROR)       state <= FAULT;
          else if (!iREN)        state <= IDLE;
          else if (rs == ACCESS) state <= IDLE;
          else if (expired)      state <= FAULT;
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion must answer ramstate in the same cycle, so this decode stays combinational on the registered state.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if ((rs == ACCESS) && d_req) begin
          dwait = 1'b0;
          if (dREN && !dWEN) dload = ramload;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if ((rs == ACCESS) && iREN) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        fault;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_arbiter #(
    .TIMEOUT(64)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .fault   (fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        is_d;

    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    nxt(); nxt();
    nRST = 1'b1;
    #1;
    check_eq("rst_iwait", 32'(iwait), 32'd1);
    check_eq("rst_dwait", 32'(dwait), 32'd1);
    check_eq("rst_ramREN", 32'(ramREN), 32'd0);
    check_eq("rst_ramWEN", 32'(ramWEN), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_iload", iload, 32'd0);
    check_eq("rst_dload", dload, 32'd0);

    // Both requesters held: expect D,I,D,I starting from last_grant=I.
    nxt();
    iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200; ramstate = FREE;
    #1;
    check_eq("alt_regd_grant", 32'(ramREN), 32'd0);
    for (int unsigned t = 0; t < 4; t++) begin
      is_d     = (t % 2 == 0);
      exp_addr = is_d ? 32'h200 : 32'h100;
      nxt();
      ramstate = BUSY;
      #1;
      check_eq("alt_addr", ramaddr, exp_addr);
      check_eq("alt_busy_wait", 32'({iwait, dwait}), 32'd3);
      nxt();
      ramstate = ACCESS; ramload = 32'hA0 + t;
      #1;
      check_eq("alt_done_wait", 32'({iwait, dwait}), is_d ? 32'd2 : 32'd1);
      check_eq("alt_load", is_d ? dload : iload, 32'hA0 + t);
      nxt();
      ramstate = FREE;
      #1;
      check_eq("alt_idle", 32'(ramREN), 32'd0);
    end
    iREN = 1'b0; dREN = 1'b0;

    // dcache read, ACCESS on third grant cycle
    nxt();
    dREN = 1'b1; daddr = 32'h40;
    #1;
    check_eq("rd_idle_ren", 32'(ramREN), 32'd0);
    nxt();
    ramstate = BUSY;
    #1;
    check_eq("rd_ren", 32'(ramREN), 32'd1);
    check_eq("rd_addr", ramaddr, 32'h40);
    check_eq("rd_iwait1", 32'(iwait), 32'd1);
    nxt();
    #1;
    check_eq("rd_dwait_busy", 32'(dwait), 32'd1);
    nxt();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check_eq("rd_dwait", 32'(dwait), 32'd0);
    check_eq("rd_dload", dload, 32'hDEADBEEF);
    check_eq("rd_iwait2", 32'(iwait), 32'd1);
    nxt();
    dREN = 1'b0; ramstate = FREE;
    #1;
    check_eq("rd_after_dwait", 32'(dwait), 32'd1);
    check_eq("rd_after_dload", dload, 32'd0);
    check_eq("rd_after_ren", 32'(ramREN), 32'd0);

    // dcache write
    nxt();
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
    #1;
    nxt();
    ramstate = BUSY;
    #1;
    check_eq("wr_wen", 32'(ramWEN), 32'd1);
    check_eq("wr_ren", 32'(ramREN), 32'd0);
    check_eq("wr_addr", ramaddr, 32'h80);
    check_eq("wr_store", ramstore, 32'h12345678);
    nxt();
    ramstate = ACCESS;
    #1;
    check_eq("wr_dwait", 32'(dwait), 32'd0);
    check_eq("wr_wen_done", 32'(ramWEN), 32'd1);
    nxt();
    dWEN = 1'b0; ramstate = FREE;
    #1;
    check_eq("wr_after_dwait", 32'(dwait), 32'd1);
    check_eq("wr_after_wen", 32'(ramWEN), 32'd0);

    // dREN and dWEN together behave as a write
    nxt();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'hC0;
    #1;
    nxt();
    ramstate = BUSY;
    #1;
    check_eq("rw_wen", 32'(ramWEN), 32'd1);
    check_eq("rw_ren", 32'(ramREN), 32'd0);
    nxt();
    ramstate = ACCESS;
    #1;
    check_eq("rw_dwait", 32'(dwait), 32'd0);
    nxt();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1;

    // icache drops its request before completion
    nxt();
    iREN = 1'b1; iaddr = 32'h300;
    #1;
    nxt();
    ramstate = BUSY;
    #1;
    check_eq("ab_ren", 32'(ramREN), 32'd1);
    check_eq("ab_addr", ramaddr, 32'h300);
    nxt();
    iREN = 1'b0; ramstate = ACCESS; ramload = 32'h55;
    #1;
    check_eq("ab_iwait", 32'(iwait), 32'd1);
    check_eq("ab_iload", iload, 32'd0);
    nxt();
    ramstate = FREE;
    #1;
    check_eq("ab_idle_ren", 32'(ramREN), 32'd0);
    check_eq("ab_idle_iwait", 32'(iwait), 32'd1);

    // reset during DGRANT
    nxt();
    dREN = 1'b1; daddr = 32'h400;
    #1;
    nxt();
    ramstate = BUSY;
    #1;
    check_eq("mr_ren", 32'(ramREN), 32'd1);
    nxt();
    nRST = 1'b0;
    #1;
    check_eq("mr_dwait_pre", 32'(dwait), 32'd1);
    nxt();
    #1;
    check_eq("mr_ren_post", 32'(ramREN), 32'd0);
    check_eq("mr_wen_post", 32'(ramWEN), 32'd0);
    check_eq("mr_dwait_post", 32'(dwait), 32'd1);
    dREN = 1'b0; nRST = 1'b1; ramstate = FREE;

    // ERROR in a grant state goes to FAULT
    nxt();
    dREN = 1'b1; daddr = 32'h500;
    #1;
    nxt();
    ramstate = ERROR;
    #1;
    check_eq("er_fault_pre", 32'(fault), 32'd0);
    check_eq("er_dwait", 32'(dwait), 32'd1);
    nxt();
    ramstate = FREE; dREN = 1'b0;
    #1;
    check_eq("er_fault", 32'(fault), 32'd1);
    check_eq("er_ren", 32'(ramREN), 32'd0);
    nRST = 1'b0;
    nxt();
    nRST = 1'b1;
    #1;
    check_eq("er_fault_rst", 32'(fault), 32'd0);

    // 64 BUSY cycles in IGRANT trip the watchdog
    nxt();
    iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
    #1;
    for (int unsigned k = 1; k <= 64; k++) begin
      nxt();
      #1;
      if (k == 1)  check_eq("to_ren_first", 32'(ramREN), 32'd1);
      if (k == 64) begin
        check_eq("to_fault_64", 32'(fault), 32'd0);
        check_eq("to_ren_64", 32'(ramREN), 32'd1);
      end
    end
    nxt();
    #1;
    check_eq("to_fault", 32'(fault), 32'd1);
    check_eq("to_ren_drop", 32'(ramREN), 32'd0);
    check_eq("to_iwait", 32'(iwait), 32'd1);
    nxt();
    ramstate = ACCESS;
    #1;
    check_eq("to_fault_hold", 32'(fault), 32'd1);
    check_eq("to_iwait_hold", 32'(iwait), 32'd1);
    nxt(); nxt();
    #1;
    check_eq("to_fault_sticky", 32'(fault), 32'd1);
    nRST = 1'b0;
    nxt();
    nRST = 1'b1; iREN = 1'b0; ramstate = FREE;
    #1;
    check_eq("to_fault_clr", 32'(fault), 32'd0);
    check_eq("to_ren_clr", 32'(ramREN), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of grant cycles without ramstate ACCESS before a fault is declared.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 nRST  in  1  reset, synchronous, active-low.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 iload  out  32  instruction word returned to icache.
REQ-007 iwait  out  1  low for exactly the cycle iload is valid; high otherwise.
REQ-008 dREN, dWEN  in  1 each  dcache read / write request.
REQ-009 daddr, dstore  in  32 each  dcache word address / write data.
REQ-010 dload  out  32  data word returned to dcache.
REQ-011 dwait  out  1  low for exactly the cycle a dcache read or write completes; high otherwise.
REQ-012 ramREN, ramWEN  out  1 each  RAM read / write strobes.
REQ-013 ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-014 ramload  in  32  RAM read data.
REQ-015 ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-016 fault  out  1  sticky RAM error or timeout indicator.

Function
REQ-017 FSM states are IDLE, DGRANT, IGRANT, and FAULT.
REQ-018 In IDLE, all ram strobes are 0, iwait=1, and dwait=1.
REQ-019 In IDLE, a pending dcache request (dREN|dWEN) moves to DGRANT and a pending iREN alone moves to IGRANT.
REQ-020 In IDLE with both pending, the arbiter moves to DGRANT unless last_grant==D, in which case it moves to IGRANT (anti-starvation).
REQ-021 last_grant is a 1-bit register updated on every grant entry.
REQ-022 The grant is registered: a request first seen in cycle N drives ram signals from cycle N+1.
REQ-023 In DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted), and iREN/iaddr are ignored.
REQ-024 In IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, and ramstore=0.
REQ-025 Completion in a grant state occurs on the cycle ramstate==ACCESS.
REQ-026 On DGRANT completion: dwait=0, dload=ramload (reads), and the next state is IDLE.
REQ-027 On IGRANT completion: iwait=0, iload=ramload, and the next state is IDLE.
REQ-028 The minimum request-to-completion latency is 1 cycle after grant, which gives a 2-cycle round trip including the IDLE decision cycle.
REQ-029 Back-to-back requests re-enter a grant state no earlier than the cycle after IDLE; requests are never pipelined.
REQ-030 If the granted requester deasserts its request before completion, the arbiter returns to IDLE next cycle, drops ram strobes, and never returns wait=0 to it.
REQ-031 A 16-bit wait counter clears on grant entry and increments each grant cycle without ACCESS.
REQ-032 When the wait counter reaches TIMEOUT, the arbiter enters FAULT.
REQ-033 ramstate==ERROR in any grant state moves the arbiter to FAULT next cycle.
REQ-034 In FAULT: fault=1, all ram strobes are 0, and iwait=dwait=1; the state is held until reset.
REQ-035 dload and iload are 0 whenever their wait signal is 1.

Reset
REQ-036 On nRST=0 at a clock edge, the arbiter enters IDLE with last_grant=I, wait counter=0, and fault=0; all outputs then take their IDLE values.
REQ-037 A reset asserted mid-grant aborts the access with no completion pulse, and ram strobes are low in the cycle after the reset edge.

Structure
REQ-038 The ramstate enum (ramstate_t) and the arbiter state enum (arbstate_t) reside in cpu_types_pkg.
REQ-039 The wait/timeout counter is a sub-module named access_watchdog (inputs: clear, enable; output: expired).
REQ-040 The arbiter itself is a single FSM plus output decode within a single file.

Verification
REQ-041 A dcache read of 0x0000_0040 with ramstate ACCESS on the 3rd grant cycle and ramload=0xDEADBEEF shall produce dwait=0 for one cycle with dload=0xDEADBEEF, and iwait shall remain 1 throughout.
REQ-042 A dcache write of 0x0000_0080 with dstore=0x1234_5678 shall produce ramWEN=1, ramREN=0, ramaddr=0x80, and ramstore=0x12345678 until ACCESS, and dwait=0 for one cycle.
REQ-043 With iREN and dREN held continuously and ACCESS every 2nd grant cycle, grants shall alternate D,I,D,I and no requester may go more than one transaction without service.
REQ-044 Asserting dREN and dWEN together shall be treated as a write (ramWEN=1, ramREN=0).
REQ-045 Holding ramstate BUSY for 64 cycles in IGRANT shall raise fault on the following cycle and drop ram strobes; fault shall stay 1 until nRST=0.
REQ-046 Pulling nRST low during DGRANT shall produce no dwait pulse, set ram strobes to 0 the next cycle, and put the arbiter in IDLE.
